// File: rtl/dwc_aw_split_ctrl.sv
// ---------------------------------------------------------------------------
// dwc_aw_split_ctrl
//
// Write-address splitter for the data-width-converter write path. One master
// AW burst is accepted and reissued as one or more slave AW sub-bursts. Each
// sub-burst is at most SLAVE_MAX_BEATS beats long. Every issued sub-burst
// pushes one bit into the write-response FIFO: 1 marks the final sub-burst
// of the master burst, 0 marks an intermediate one.
//
// Optional feature macro: DWC_AW_SPLIT_STATS_EN
//   defined   -> adds SPLIT_COUNT[15:0]. It is a saturating count of master
//                bursts that were split into two or more sub-bursts.
//   undefined -> SPLIT_COUNT port and counter are absent.
//
// Ports:
//   ACLK, sysReset           clock, synchronous active-high reset
//   MASTER_AW*               master AW channel (MASTER_AWREADY high in IDLE)
//   SLAVE_AW*                slave AW channel; payload registered
//   bresp_fifo_full          response FIFO full; blocks SLAVE_AWVALID
//   brespFifowe              FIFO push, same cycle as the slave handshake
//   brespFifoWrData          1 = final sub-burst of the master burst
//   dbg_state                current FSM state (0 = IDLE, 1 = ISSUE)
//   SPLIT_COUNT              (optional) count of split master bursts
//
// Handshake rule: a transfer happens on a rising ACLK edge where valid and
// ready are both high. Valid never depends on ready. Valid stays high, with
// a stable payload, until the transfer. The only exception is sysReset,
// which abandons a sub-burst in flight.
// ---------------------------------------------------------------------------
module dwc_aw_split_ctrl #(
  parameter int ID_WIDTH        = 1,
  parameter int USER_WIDTH      = 1,
  parameter int ADDR_WIDTH      = 32,
  parameter int SLAVE_MAX_BEATS = 16
) (
  input  logic                  ACLK,
  input  logic                  sysReset,
  input  logic [ID_WIDTH-1:0]   MASTER_AWID,
  input  logic [ADDR_WIDTH-1:0] MASTER_AWADDR,
  input  logic [7:0]            MASTER_AWLEN,
  input  logic [2:0]            MASTER_AWSIZE,
  input  logic [1:0]            MASTER_AWBURST,
  input  logic [3:0]            MASTER_AWCACHE,
  input  logic [2:0]            MASTER_AWPROT,
  input  logic [USER_WIDTH-1:0] MASTER_AWUSER,
  input  logic                  MASTER_AWVALID,
  output logic                  MASTER_AWREADY,
  output logic [ID_WIDTH-1:0]   SLAVE_AWID,
  output logic [ADDR_WIDTH-1:0] SLAVE_AWADDR,
  output logic [7:0]            SLAVE_AWLEN,
  output logic [2:0]            SLAVE_AWSIZE,
  output logic [1:0]            SLAVE_AWBURST,
  output logic [3:0]            SLAVE_AWCACHE,
  output logic [2:0]            SLAVE_AWPROT,
  output logic [USER_WIDTH-1:0] SLAVE_AWUSER,
  output logic                  SLAVE_AWVALID,
  input  logic                  SLAVE_AWREADY,
  input  logic                  bresp_fifo_full,
  output logic                  brespFifowe,
  output logic                  brespFifoWrData,
  output logic [0:0]            dbg_state
`ifdef DWC_AW_SPLIT_STATS_EN
  ,
  output logic [15:0]           SPLIT_COUNT
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [8:0] MAX_BEATS  = 9'(SLAVE_MAX_BEATS);

  logic [0:0] state_q;
  logic [8:0] rem_q;       // beats of the master burst not yet issued

  logic                  is_incr;
  logic                  hs;
  logic [8:0]            beats;
  logic [8:0]            rem_next;
  logic [7:0]            len_next;
  logic [8:0]            cap_rem;
  logic [7:0]            cap_len;
  logic [ADDR_WIDTH-1:0] addr_step;

  assign dbg_state      = state_q;
  assign MASTER_AWREADY = (state_q == IDLE);

  // sysReset gates valid so that a sub-burst in flight in the reset cycle
  // gets neither a slave handshake nor a FIFO push.
  assign SLAVE_AWVALID   = (state_q == ISSUE) && !bresp_fifo_full && !sysReset;
  assign hs              = SLAVE_AWVALID && SLAVE_AWREADY;
  assign brespFifowe     = hs;

  assign is_incr         = (SLAVE_AWBURST == BURST_INCR);
  assign brespFifoWrData = (rem_q <= MAX_BEATS) || !is_incr;

  // The current sub-burst length is held in SLAVE_AWLEN, so its beat count
  // follows from that register directly.
  assign beats     = {1'b0, SLAVE_AWLEN} + 9'd1;
  assign rem_next  = rem_q - beats;
  assign len_next  = (rem_next > MAX_BEATS) ? 8'(MAX_BEATS - 9'd1)
                                            : 8'(rem_next - 9'd1);
  assign addr_step = ADDR_WIDTH'(beats) << SLAVE_AWSIZE;

  // FIXED and WRAP bursts pass through with their original length.
  assign cap_rem = {1'b0, MASTER_AWLEN} + 9'd1;
  assign cap_len = ((MASTER_AWBURST == BURST_INCR) && (cap_rem > MAX_BEATS))
                   ? 8'(MAX_BEATS - 9'd1) : MASTER_AWLEN;

  always_ff @(posedge ACLK) begin
    if (sysReset) begin
      state_q       <= IDLE;
      rem_q         <= '0;
      SLAVE_AWID    <= '0;
      SLAVE_AWADDR  <= '0;
      SLAVE_AWLEN   <= '0;
      SLAVE_AWSIZE  <= '0;
      SLAVE_AWBURST <= '0;
      SLAVE_AWCACHE <= '0;
      SLAVE_AWPROT  <= '0;
      SLAVE_AWUSER  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MASTER_AWVALID) begin
            state_q       <= ISSUE;
            rem_q         <= cap_rem;
            SLAVE_AWID    <= MASTER_AWID;
            SLAVE_AWADDR  <= MASTER_AWADDR;
            SLAVE_AWLEN   <= cap_len;
            SLAVE_AWSIZE  <= MASTER_AWSIZE;
            SLAVE_AWBURST <= MASTER_AWBURST;
            SLAVE_AWCACHE <= MASTER_AWCACHE;
            SLAVE_AWPROT  <= MASTER_AWPROT;
            SLAVE_AWUSER  <= MASTER_AWUSER;
          end
        end
        ISSUE: begin
          if (hs) begin
            rem_q        <= rem_next;
            SLAVE_AWADDR <= SLAVE_AWADDR + addr_step;
            if (brespFifoWrData) begin
              state_q <= IDLE;
            end else begin
              SLAVE_AWLEN <= len_next;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DWC_AW_SPLIT_STATS_EN
  // split_q records that the current master burst has already pushed an
  // intermediate sub-burst. The final push then counts it as split.
  logic split_q;

  always_ff @(posedge ACLK) begin
    if (sysReset) begin
      split_q     <= 1'b0;
      SPLIT_COUNT <= '0;
    end else if (hs) begin
      if (brespFifoWrData) begin
        split_q <= 1'b0;
        if (split_q && (SPLIT_COUNT != 16'hFFFF)) begin
          SPLIT_COUNT <= SPLIT_COUNT + 16'd1;
        end
      end else begin
        split_q <= 1'b1;
      end
    end
  end
`endif

endmodule
